// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_LD = 2'd1,
    BUSY_ST = 2'd2
  } state_t;

  localparam logic BMS_WORD = 1'b0;
  localparam logic BMS_BYTE = 1'b1;

  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH-byte storage: combinational read of four consecutive bytes starting at
// rd_idx (wrapping), synchronous byte-enabled write of four lanes from wr_idx.
module dmem_byte_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [3:0]               wr_be,
  input  logic [31:0]              wr_data
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];

  // Lane gi holds the byte at index+gi, so lane 0 is the little-endian LSB.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      logic [AW-1:0] rd_lane_idx;
      assign rd_lane_idx = rd_idx + AW'(gi);
      assign rd_data[8*gi +: 8] = mem[rd_lane_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[wr_idx + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory access stage: fixed-latency byte/word loads and stores on a private array.
// Optional macro DMEM_SIGN_EXTEND_EN: byte loads sign-extend (LB) instead of zero-extend (LBU).
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int TAG_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req_valid,
  input  logic [31:0]      ld_req_addr,
  input  logic             ld_req_BMS,
  input  logic [TAG_W-1:0] ld_req_rd_tag,
  input  logic [TAG_W-1:0] ld_req_ROB_index,
  input  logic             st_req_valid,
  input  logic [31:0]      st_req_addr,
  input  logic             st_req_BMS,
  input  logic [31:0]      st_req_data,
  output logic             req_ready,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_resp_value,
  output logic [TAG_W-1:0] ld_resp_rd_tag,
  output logic [TAG_W-1:0] ld_resp_ROB_index,
  output logic             st_done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [AW-1:0]    lat_idx_reg;
  logic             lat_bms_reg;
  logic [31:0]      lat_data_reg;
  logic [TAG_W-1:0] lat_tag_reg, lat_rob_reg;

  logic          accept_st, accept_ld, access_now;
  logic [AW-1:0] ld_idx, st_idx;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   rd_data, ld_value;

  // Upper address bits are ignored so the array wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_req_addr[31:AW], st_req_addr[31:AW]};

  assign accept_st  = (state_reg == IDLE) && st_req_valid;
  assign accept_ld  = (state_reg == IDLE) && !st_req_valid && ld_req_valid;
  assign access_now = (state_reg != IDLE) && (cnt_reg == '0);

  assign ld_idx = (ld_req_BMS == BMS_WORD) ? {ld_req_addr[AW-1:2], 2'b00} : ld_req_addr[AW-1:0];
  assign st_idx = (st_req_BMS == BMS_WORD) ? {st_req_addr[AW-1:2], 2'b00} : st_req_addr[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (st_req_valid)      state_next = BUSY_ST;
        else if (ld_req_valid) state_next = BUSY_LD;
      end
      BUSY_LD, BUSY_ST: begin
        if (cnt_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    wr_en     = (state_reg == BUSY_ST) && (cnt_reg == '0);
    wr_be     = (lat_bms_reg == BMS_BYTE) ? 4'b0001 : 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      lat_idx_reg  <= '0;
      lat_bms_reg  <= BMS_WORD;
      lat_data_reg <= '0;
      lat_tag_reg  <= '0;
      lat_rob_reg  <= '0;
    end else if (accept_st) begin
      cnt_reg      <= CNT_W'(LATENCY - 1);
      lat_idx_reg  <= st_idx;
      lat_bms_reg  <= st_req_BMS;
      lat_data_reg <= st_req_data;
    end else if (accept_ld) begin
      cnt_reg      <= CNT_W'(LATENCY - 1);
      lat_idx_reg  <= ld_idx;
      lat_bms_reg  <= ld_req_BMS;
      lat_tag_reg  <= ld_req_rd_tag;
      lat_rob_reg  <= ld_req_ROB_index;
    end else if (state_reg != IDLE && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  dmem_byte_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rd_idx  (lat_idx_reg),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (lat_idx_reg),
    .wr_be   (wr_be),
    .wr_data (lat_data_reg)
  );

  always_comb begin
    ld_value = rd_data;
    if (lat_bms_reg == BMS_BYTE) begin
`ifdef DMEM_SIGN_EXTEND_EN
      ld_value = {{24{rd_data[7]}}, rd_data[7:0]};
`else
      ld_value = {24'b0, rd_data[7:0]};
`endif
    end
  end

  // Response fields hold between loads; only the valid/done pulses clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_resp_valid     <= 1'b0;
      st_done           <= 1'b0;
      ld_resp_value     <= '0;
      ld_resp_rd_tag    <= '0;
      ld_resp_ROB_index <= '0;
    end else begin
      ld_resp_valid <= access_now && (state_reg == BUSY_LD);
      st_done       <= access_now && (state_reg == BUSY_ST);
      if (access_now && state_reg == BUSY_LD) begin
        ld_resp_value     <= ld_value;
        ld_resp_rd_tag    <= lat_tag_reg;
        ld_resp_ROB_index <= lat_rob_reg;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: stimulus pushes expected responses, a
// monitor pops and compares on every ld_resp_valid / st_done pulse.
module tb_data_mem_unit;

  localparam int LATENCY = 2;
  localparam int TAG_W   = 6;

  typedef struct {
    logic             is_load;
    logic [31:0]      value;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] rob;
    int               acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ld_req_valid = 1'b0;
  logic [31:0]      ld_req_addr = '0;
  logic             ld_req_BMS = 1'b0;
  logic [TAG_W-1:0] ld_req_rd_tag = '0;
  logic [TAG_W-1:0] ld_req_ROB_index = '0;
  logic             st_req_valid = 1'b0;
  logic [31:0]      st_req_addr = '0;
  logic             st_req_BMS = 1'b0;
  logic [31:0]      st_req_data = '0;
  logic             req_ready;
  logic             ld_resp_valid;
  logic [31:0]      ld_resp_value;
  logic [TAG_W-1:0] ld_resp_rd_tag;
  logic [TAG_W-1:0] ld_resp_ROB_index;
  logic             st_done;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  data_mem_unit #(.DEPTH(1024), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .ld_req_valid      (ld_req_valid),
    .ld_req_addr       (ld_req_addr),
    .ld_req_BMS        (ld_req_BMS),
    .ld_req_rd_tag     (ld_req_rd_tag),
    .ld_req_ROB_index  (ld_req_ROB_index),
    .st_req_valid      (st_req_valid),
    .st_req_addr       (st_req_addr),
    .st_req_BMS        (st_req_BMS),
    .st_req_data       (st_req_data),
    .req_ready         (req_ready),
    .ld_resp_valid     (ld_resp_valid),
    .ld_resp_value     (ld_resp_value),
    .ld_resp_rd_tag    (ld_resp_rd_tag),
    .ld_resp_ROB_index (ld_resp_ROB_index),
    .st_done           (st_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (ld_resp_valid || st_done) begin
      if (ld_resp_valid && st_done) begin
        check("both_pulses", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'b0, ld_resp_valid}, {31'b0, st_done});
        errors++;
        checks++;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_kind", {31'b0, ld_resp_valid}, {31'b0, e.is_load});
        check("latency", cyc - e.acc_cyc, LATENCY);
        if (e.is_load) begin
          check("ld_value", ld_resp_value, e.value);
          check("ld_tag", 32'(ld_resp_rd_tag), 32'(e.tag));
          check("ld_rob", 32'(ld_resp_ROB_index), 32'(e.rob));
          $display("load  resp value=0x%08h tag=%0d rob=%0d", ld_resp_value, ld_resp_rd_tag, ld_resp_ROB_index);
        end else begin
          $display("store done");
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic bms, input logic [31:0] data);
    exp_t e;
    wait_ready();
    st_req_valid = 1'b1; st_req_addr = addr; st_req_BMS = bms; st_req_data = data;
    @(posedge clk); #1;
    st_req_valid = 1'b0;
    e.is_load = 1'b0; e.value = '0; e.tag = '0; e.rob = '0; e.acc_cyc = cyc;
    exp_q.push_back(e);
    $display("store addr=0x%08h bms=%0d data=0x%08h", addr, bms, data);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic bms, input logic [TAG_W-1:0] tag,
                         input logic [TAG_W-1:0] rob, input logic [31:0] exp_val);
    exp_t e;
    wait_ready();
    ld_req_valid = 1'b1; ld_req_addr = addr; ld_req_BMS = bms;
    ld_req_rd_tag = tag; ld_req_ROB_index = rob;
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    e.is_load = 1'b1; e.value = exp_val; e.tag = tag; e.rob = rob; e.acc_cyc = cyc;
    exp_q.push_back(e);
    $display("load  addr=0x%08h bms=%0d tag=%0d rob=%0d expect=0x%08h", addr, bms, tag, rob, exp_val);
  endtask

  initial begin
    int   n;
    exp_t e;
    logic [31:0] sign_exp;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_ld_valid", {31'b0, ld_resp_valid}, 32'd0);
    check("rst_st_done", {31'b0, st_done}, 32'd0);
    check("rst_value", ld_resp_value, 32'd0);
    reset = 1'b0;

    // Word store then load.
    do_store(32'd4, 1'b0, 32'h0000000A);
    do_load(32'd4, 1'b0, 6'd6, 6'd6, 32'h0000000A);

    // Byte lanes.
    do_store(32'd8, 1'b0, 32'h11223344);
    do_store(32'd9, 1'b1, 32'hAAAAAAFF);
    do_load(32'd8, 1'b0, 6'd1, 6'd2, 32'h1122FF44);
    do_load(32'd11, 1'b1, 6'd3, 6'd4, 32'h00000011);

    // Simultaneous request: store wins, load held until ready returns.
    wait_ready();
    st_req_valid = 1'b1; st_req_addr = 32'd12; st_req_BMS = 1'b0; st_req_data = 32'h00001000;
    ld_req_valid = 1'b1; ld_req_addr = 32'd12; ld_req_BMS = 1'b0;
    ld_req_rd_tag = 6'd5; ld_req_ROB_index = 6'd7;
    @(posedge clk); #1;
    st_req_valid = 1'b0;
    e.is_load = 1'b0; e.value = '0; e.tag = '0; e.rob = '0; e.acc_cyc = cyc;
    exp_q.push_back(e);
    $display("simultaneous store+load addr=12");
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, LATENCY);
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    e.is_load = 1'b1; e.value = 32'h00001000; e.tag = 6'd5; e.rob = 6'd7; e.acc_cyc = cyc;
    exp_q.push_back(e);
    $display("held load accepted");

    // Alignment by truncation and wrap at DEPTH.
    do_store(32'h00000403, 1'b0, 32'hDEADBEEF);
    do_load(32'd0, 1'b0, 6'd10, 6'd11, 32'hDEADBEEF);
    do_load(32'h00000406, 1'b0, 6'd12, 6'd13, 32'h0000000A);

    // Byte extension option.
`ifdef DMEM_SIGN_EXTEND_EN
    sign_exp = 32'hFFFFFF80;
`else
    sign_exp = 32'h00000080;
`endif
    do_store(32'd16, 1'b1, 32'hABCDEF80);
    do_load(32'd16, 1'b1, 6'd20, 6'd21, sign_exp);

    // Drain before the reset test.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain1", exp_q.size(), 0);

    // Reset one cycle after accepting a load: no response may ever appear.
    wait_ready();
    ld_req_valid = 1'b1; ld_req_addr = 32'd8; ld_req_BMS = 1'b0;
    ld_req_rd_tag = 6'd9; ld_req_ROB_index = 6'd9;
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_ld_valid", {31'b0, ld_resp_valid}, 32'd0);
    check("midrst_value", ld_resp_value, 32'd0);
    check("midrst_tag", 32'(ld_resp_rd_tag), 32'd0);
    check("midrst_rob", 32'(ld_resp_ROB_index), 32'd0);
    $display("reset asserted mid-load");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
